// File: rtl/godai_fetch_tracer.sv
// Passive instruction-fetch monitor: pairs granted addresses with returned words,
// timestamps grant/response and buffers records in a show-ahead trace FIFO.
module godai_fetch_tracer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TS_WIDTH        = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DEPTH           = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_i,
    input  logic                       instr_req_i,
    input  logic                       instr_gnt_i,
    input  logic [ADDR_WIDTH-1:0]      instr_addr_i,
    input  logic                       instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      instr_rdata_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [ADDR_WIDTH-1:0]      trace_addr_o,
    output logic [DATA_WIDTH-1:0]      trace_rdata_o,
    output logic [TS_WIDTH-1:0]        trace_gnt_ts_o,
    output logic [TS_WIDTH-1:0]        trace_rsp_ts_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic [15:0]                drop_count_o,
    output logic                       protocol_err_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PCW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [TS_WIDTH-1:0]   gts;
        logic [TS_WIDTH-1:0]   rts;
    } rec_t;

    logic [TS_WIDTH-1:0]   ts_q;

    logic [ADDR_WIDTH-1:0] pend_addr_q [MAX_OUTSTANDING];
    logic [TS_WIDTH-1:0]   pend_ts_q   [MAX_OUTSTANDING];
    logic                  pend_en_q   [MAX_OUTSTANDING];
    logic [PW-1:0]         pend_rd_q, pend_wr_q;
    logic [PCW-1:0]        pend_cnt_q, pend_cnt_d;

    rec_t                  fifo_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [FW-1:0]         fill_q, fill_d;
    logic [15:0]           drop_q;
    logic                  err_q;

    logic gnt, pend_empty, pend_full, pend_push, pend_pop, err_set;
    logic rec_push, f_full, f_pop, f_push, f_drop;
    rec_t rec_new, rec_head;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // The rvalid always retires the oldest entry, so a full queue can take a
    // same-cycle grant only because the pop frees a slot.
    always_comb begin
        gnt        = instr_req_i && instr_gnt_i;
        pend_empty = (pend_cnt_q == '0);
        pend_full  = (pend_cnt_q == PCW'(MAX_OUTSTANDING));
        pend_pop   = instr_rvalid_i && !pend_empty;
        pend_push  = gnt && (!pend_full || instr_rvalid_i);
        err_set    = (instr_rvalid_i && pend_empty) || (gnt && pend_full && !instr_rvalid_i);
        pend_cnt_d = pend_cnt_q + PCW'(pend_push) - PCW'(pend_pop);

        rec_push   = pend_pop && pend_en_q[pend_rd_q];
        rec_new    = '{addr: pend_addr_q[pend_rd_q], data: instr_rdata_i,
                       gts: pend_ts_q[pend_rd_q], rts: ts_q};
        f_full     = (fill_q == FW'(DEPTH));
        f_pop      = (fill_q != '0) && trace_ready_i;
        f_push     = rec_push && (!f_full || f_pop);
        f_drop     = rec_push && f_full && !f_pop;
        fill_d     = fill_q + FW'(f_push) - FW'(f_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= '0;
            pend_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ts_q       <= ts_q + TS_WIDTH'(1);
            pend_cnt_q <= pend_cnt_d;
            fill_q     <= fill_d;
            if (pend_push) pend_wr_q <= pend_inc(pend_wr_q);
            if (pend_pop)  pend_rd_q <= pend_inc(pend_rd_q);
            if (f_push)    wr_ptr_q  <= wr_ptr_q + AW'(1);
            if (f_pop)     rd_ptr_q  <= rd_ptr_q + AW'(1);
            if (f_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (err_set)   err_q     <= 1'b1;
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && pend_push) begin
            pend_addr_q[pend_wr_q] <= instr_addr_i;
            pend_ts_q[pend_wr_q]   <= ts_q;
            pend_en_q[pend_wr_q]   <= enable_i;
        end
        if (!rst && f_push) fifo_q[wr_ptr_q] <= rec_new;
    end

    // Data outputs are forced to zero while empty so reset leaves all outputs at 0.
    always_comb begin
        rec_head       = (fill_q != '0) ? fifo_q[rd_ptr_q] : '0;
        trace_valid_o  = (fill_q != '0);
        trace_addr_o   = rec_head.addr;
        trace_rdata_o  = rec_head.data;
        trace_gnt_ts_o = rec_head.gts;
        trace_rsp_ts_o = rec_head.rts;
        fill_o         = fill_q;
        drop_count_o   = drop_q;
        protocol_err_o = err_q;
    end
endmodule
